// File: rtl/spi_reg_bridge.sv
// Frame-level bridge behind the SPI byte engine: decodes a command byte, then
// runs an auto-incrementing register write or read burst on a simple register bus.
module spi_reg_bridge #(
   parameter int unsigned ADDR_W    = 7,
   parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              spi_ss,
   input  logic              rx_valid,
   input  logic [7:0]        rx_byte,
   output logic [7:0]        tx_data,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [7:0]        reg_rdata,
   output logic              frame_active,
   output logic              overrun
);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      RD_REQ,
      RD_CAP
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] cmd_addr;

   always_comb begin
      cmd_addr = ADDR_W'(rx_byte[6:0]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         tx_data      <= IDLE_BYTE;
         reg_addr     <= '0;
         reg_wdata    <= '0;
         reg_we       <= 1'b0;
         reg_re       <= 1'b0;
         frame_active <= 1'b0;
         overrun      <= 1'b0;
      end else if (ena) begin
         reg_we <= 1'b0;
         reg_re <= 1'b0;
         if (spi_ss) begin
            state        <= IDLE;
            frame_active <= 1'b0;
            tx_data      <= IDLE_BYTE;
         end else begin
            case (state)
               IDLE: begin
                  if (rx_valid) begin
                     reg_addr     <= cmd_addr;
                     frame_active <= 1'b1;
                     overrun      <= 1'b0;
                     if (rx_byte[7]) begin
                        state <= WRITE;
                     end else begin
                        state  <= RD_REQ;
                        reg_re <= 1'b1;
                     end
                  end
               end
               WRITE: begin
                  // Address advances in the cycle after the strobe, so a byte
                  // arriving in that same cycle still writes the next address.
                  if (reg_we) begin
                     reg_addr <= reg_addr + ADDR_W'(1);
                  end
                  if (rx_valid) begin
                     reg_wdata <= rx_byte;
                     reg_we    <= 1'b1;
                  end
               end
               RD_REQ: begin
                  // reg_re high marks the request cycle; low means waiting for
                  // the next dummy byte before fetching the following address.
                  if (reg_re) begin
                     state <= RD_CAP;
                     if (rx_valid) begin
                        overrun <= 1'b1;
                     end
                  end else if (rx_valid) begin
                     reg_re <= 1'b1;
                  end
               end
               RD_CAP: begin
                  tx_data  <= reg_rdata;
                  reg_addr <= reg_addr + ADDR_W'(1);
                  state    <= RD_REQ;
                  if (rx_valid) begin
                     overrun <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: directed frame scenarios plus random bursts checked
// against a transaction-level register model.
module tb_spi_reg_bridge;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b1;
   logic       spi_ss = 1'b1;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic [7:0] tx_data;
   logic [6:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_rdata;
   logic       frame_active;
   logic       overrun;

   int total = 0;
   int bad = 0;
   int both_hi = 0;
   logic mem_load = 1'b1;

   logic [7:0]  bus_mem [128];
   logic [7:0]  exp_mem [128];
   logic [14:0] act_wr [$];
   logic [6:0]  act_rd [$];

   spi_reg_bridge #(.ADDR_W(7), .IDLE_BYTE(8'h00)) dut (
      .clk(clk), .rst(rst), .ena(ena), .spi_ss(spi_ss),
      .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_data(tx_data),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
      .reg_re(reg_re), .reg_rdata(reg_rdata),
      .frame_active(frame_active), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Register-bus slave: read data appears the cycle after reg_re and holds.
   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 128; i++) bus_mem[i] <= 8'(8'hA0 + i);
         reg_rdata <= 8'h00;
      end else if (ena) begin
         if (reg_we) begin
            act_wr.push_back({reg_addr, reg_wdata});
            bus_mem[reg_addr] <= reg_wdata;
         end
         if (reg_re) begin
            act_rd.push_back(reg_addr);
            reg_rdata <= bus_mem[reg_addr];
         end
         if (reg_we && reg_re) both_hi++;
      end
   end

   task automatic send(input logic [7:0] b);
      rx_byte = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic frame_end();
      spi_ss = 1'b1;
      repeat (2) @(negedge clk);
      spi_ss = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; spi_ss = 1'b1; ena = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({tx_data, reg_addr, reg_wdata, reg_we, reg_re, frame_active, overrun} !== 27'h0) begin
         bad++;
         $display("FAIL reset_values got=%h exp=%h",
                  {tx_data, reg_addr, reg_wdata, reg_we, reg_re, frame_active, overrun}, 27'h0);
      end
      rst = 1'b0; spi_ss = 1'b0;
      repeat (2) @(negedge clk);
      act_wr.delete(); act_rd.delete();
   endtask

   task automatic test_read_burst();
      act_wr.delete(); act_rd.delete();
      send(8'h10);
      total++;
      if ({reg_re, reg_we, reg_addr, frame_active} !== {1'b1, 1'b0, 7'h10, 1'b1}) begin
         bad++;
         $display("FAIL read_req got=%b%b_%h_%b exp=10_10_1", reg_re, reg_we, reg_addr, frame_active);
      end
      @(negedge clk);
      total++;
      if ({reg_re, reg_addr} !== {1'b0, 7'h10}) begin
         bad++;
         $display("FAIL read_req_width got=%b_%h exp=0_10", reg_re, reg_addr);
      end
      @(negedge clk);
      total++;
      if ({tx_data, reg_addr} !== {8'hB0, 7'h11}) begin
         bad++;
         $display("FAIL read_cap0 got=%h_%h exp=b0_11", tx_data, reg_addr);
      end
      repeat (3) @(negedge clk);
      send(8'h00);
      total++;
      if ({reg_re, reg_addr} !== {1'b1, 7'h11}) begin
         bad++;
         $display("FAIL read_req1 got=%b_%h exp=1_11", reg_re, reg_addr);
      end
      repeat (2) @(negedge clk);
      total++;
      if (tx_data !== 8'hB1) begin
         bad++;
         $display("FAIL read_cap1 got=%h exp=b1", tx_data);
      end
      frame_end();
      total++;
      if (act_rd.size() != 2 || act_wr.size() != 0 || act_rd[0] !== 7'h10 || act_rd[1] !== 7'h11) begin
         bad++;
         $display("FAIL read_bus got_rd=%0d got_wr=%0d exp_rd=2 exp_wr=0", act_rd.size(), act_wr.size());
      end
   endtask

   task automatic test_write_burst();
      act_wr.delete(); act_rd.delete();
      send(8'h85);
      repeat (3) @(negedge clk);
      send(8'h11);
      total++;
      if ({reg_we, reg_re, reg_addr, reg_wdata} !== {1'b1, 1'b0, 7'h05, 8'h11}) begin
         bad++;
         $display("FAIL write0 got=%b%b_%h_%h exp=10_05_11", reg_we, reg_re, reg_addr, reg_wdata);
      end
      @(negedge clk);
      total++;
      if ({reg_we, reg_addr} !== {1'b0, 7'h06}) begin
         bad++;
         $display("FAIL write0_incr got=%b_%h exp=0_06", reg_we, reg_addr);
      end
      repeat (2) @(negedge clk);
      send(8'h22);
      total++;
      if ({reg_we, reg_addr, reg_wdata} !== {1'b1, 7'h06, 8'h22}) begin
         bad++;
         $display("FAIL write1 got=%b_%h_%h exp=1_06_22", reg_we, reg_addr, reg_wdata);
      end
      repeat (3) @(negedge clk);
      total++;
      if ({tx_data, frame_active} !== {8'h00, 1'b1}) begin
         bad++;
         $display("FAIL write_frame got=%h_%b exp=00_1", tx_data, frame_active);
      end
      exp_mem[5] = 8'h11;
      exp_mem[6] = 8'h22;
      frame_end();
      total++;
      if (act_wr.size() != 2 || act_rd.size() != 0 || act_wr[0] !== {7'h05, 8'h11}
          || act_wr[1] !== {7'h06, 8'h22} || frame_active !== 1'b0) begin
         bad++;
         $display("FAIL write_bus got_wr=%0d got_rd=%0d fa=%b exp_wr=2 exp_rd=0 fa=0",
                  act_wr.size(), act_rd.size(), frame_active);
      end
   endtask

   task automatic test_wrap();
      logic [7:0]  d [3];
      logic [6:0]  ea [3];
      bit ok;
      act_wr.delete(); act_rd.delete();
      ea[0] = 7'h7F; ea[1] = 7'h00; ea[2] = 7'h01;
      send(8'hFF);
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         d[k] = 8'($urandom);
         send(d[k]);
         exp_mem[ea[k]] = d[k];
         repeat (3) @(negedge clk);
      end
      frame_end();
      ok = (act_wr.size() == 3);
      if (ok) for (int k = 0; k < 3; k++) if (act_wr[k] !== {ea[k], d[k]}) ok = 1'b0;
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL wrap_addrs got_n=%0d first=%h exp_n=3 first=%h",
                  act_wr.size(), (act_wr.size() > 0) ? act_wr[0] : 15'h0, {ea[0], d[0]});
      end
   endtask

   task automatic test_abort();
      act_wr.delete(); act_rd.delete();
      send(8'h83);
      repeat (3) @(negedge clk);
      send(8'h44);
      spi_ss = 1'b1;
      total++;
      if ({reg_we, reg_addr} !== {1'b1, 7'h03}) begin
         bad++;
         $display("FAIL abort_pending got=%b_%h exp=1_03", reg_we, reg_addr);
      end
      @(negedge clk);
      exp_mem[3] = 8'h44;
      total++;
      if ({reg_we, reg_re, frame_active, tx_data, reg_addr} !== {3'b000, 8'h00, 7'h03}) begin
         bad++;
         $display("FAIL abort_state got=%b%b%b_%h_%h exp=000_00_03",
                  reg_we, reg_re, frame_active, tx_data, reg_addr);
      end
      send(8'h81);
      @(negedge clk);
      spi_ss = 1'b0;
      @(negedge clk);
      send(8'h05);
      total++;
      if ({reg_re, reg_addr, frame_active} !== {1'b1, 7'h05, 1'b1}) begin
         bad++;
         $display("FAIL abort_newcmd got=%b_%h_%b exp=1_05_1", reg_re, reg_addr, frame_active);
      end
      repeat (2) @(negedge clk);
      total++;
      if (tx_data !== exp_mem[5]) begin
         bad++;
         $display("FAIL abort_read got=%h exp=%h", tx_data, exp_mem[5]);
      end
      frame_end();
      total++;
      if (act_wr.size() != 1 || act_rd.size() != 1 || act_wr[0] !== {7'h03, 8'h44}
          || act_rd[0] !== 7'h05 || tx_data !== 8'h00) begin
         bad++;
         $display("FAIL abort_bus got_wr=%0d got_rd=%0d tx=%h exp_wr=1 exp_rd=1 tx=00",
                  act_wr.size(), act_rd.size(), tx_data);
      end
   endtask

   task automatic test_overrun();
      act_wr.delete(); act_rd.delete();
      send(8'h30);
      rx_byte = 8'h99;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      total++;
      if (overrun !== 1'b1) begin
         bad++;
         $display("FAIL overrun_set got=%b exp=1", overrun);
      end
      @(negedge clk);
      total++;
      if ({tx_data, reg_addr} !== {exp_mem[7'h30], 7'h31}) begin
         bad++;
         $display("FAIL overrun_cap got=%h_%h exp=%h_31", tx_data, reg_addr, exp_mem[7'h30]);
      end
      repeat (3) @(negedge clk);
      total++;
      if (act_rd.size() != 1 || act_rd[0] !== 7'h30 || reg_re !== 1'b0) begin
         bad++;
         $display("FAIL overrun_ignored got_rd=%0d re=%b exp_rd=1 re=0", act_rd.size(), reg_re);
      end
      frame_end();
      total++;
      if (overrun !== 1'b1) begin
         bad++;
         $display("FAIL overrun_sticky got=%b exp=1", overrun);
      end
      send(8'h90);
      total++;
      if (overrun !== 1'b0) begin
         bad++;
         $display("FAIL overrun_clear got=%b exp=0", overrun);
      end
      frame_end();
   endtask

   task automatic test_reset_ena();
      act_wr.delete(); act_rd.delete();
      send(8'h40);
      @(negedge clk);
      ena = 1'b0;
      repeat (5) @(negedge clk);
      total++;
      if ({tx_data, reg_addr, reg_re} !== {8'h00, 7'h40, 1'b0}) begin
         bad++;
         $display("FAIL ena_freeze got=%h_%h_%b exp=00_40_0", tx_data, reg_addr, reg_re);
      end
      ena = 1'b1;
      @(negedge clk);
      total++;
      if ({tx_data, reg_addr} !== {exp_mem[7'h40], 7'h41}) begin
         bad++;
         $display("FAIL ena_resume got=%h_%h exp=%h_41", tx_data, reg_addr, exp_mem[7'h40]);
      end
      repeat (2) @(negedge clk);
      send(8'h00);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({tx_data, reg_addr, reg_wdata, reg_we, reg_re, frame_active, overrun} !== 27'h0) begin
         bad++;
         $display("FAIL rst_midburst got=%h exp=%h",
                  {tx_data, reg_addr, reg_wdata, reg_we, reg_re, frame_active, overrun}, 27'h0);
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      total++;
      if (act_rd.size() != 2 || act_rd[1] !== 7'h41 || reg_re !== 1'b0 || act_wr.size() != 0) begin
         bad++;
         $display("FAIL rst_nostrobe got_rd=%0d re=%b exp_rd=2 re=0", act_rd.size(), reg_re);
      end
   endtask

   task automatic test_random_frames();
      logic [7:0]  cmd, b, etx;
      logic [6:0]  base, a;
      logic [14:0] ew [$];
      logic [6:0]  er [$];
      int n;
      bit ok;
      for (int f = 0; f < 25; f++) begin
         act_wr.delete(); act_rd.delete(); ew.delete(); er.delete();
         cmd = 8'($urandom);
         base = cmd[6:0];
         n = $urandom_range(1, 5);
         send(cmd);
         if (!cmd[7]) er.push_back(base);
         repeat ($urandom_range(2, 5)) @(negedge clk);
         etx = cmd[7] ? 8'h00 : exp_mem[base];
         total++;
         if (tx_data !== etx || frame_active !== 1'b1) begin
            bad++;
            $display("FAIL rand%0d_cmd tx=%h fa=%b exp tx=%h fa=1", f, tx_data, frame_active, etx);
         end
         for (int k = 1; k <= n; k++) begin
            b = 8'($urandom);
            send(b);
            if (cmd[7]) begin
               a = base + 7'(k - 1);
               ew.push_back({a, b});
               exp_mem[a] = b;
               etx = 8'h00;
            end else begin
               a = base + 7'(k);
               er.push_back(a);
               etx = exp_mem[a];
            end
            repeat ($urandom_range(2, 5)) @(negedge clk);
            total++;
            if (tx_data !== etx) begin
               bad++;
               $display("FAIL rand%0d_byte%0d tx=%h exp=%h", f, k, tx_data, etx);
            end
         end
         frame_end();
         ok = (act_wr.size() == ew.size()) && (act_rd.size() == er.size());
         if (ok) foreach (ew[i]) if (act_wr[i] !== ew[i]) ok = 1'b0;
         if (ok) foreach (er[i]) if (act_rd[i] !== er[i]) ok = 1'b0;
         total++;
         if (!ok) begin
            bad++;
            $display("FAIL rand%0d_bus got_wr=%0d got_rd=%0d exp_wr=%0d exp_rd=%0d",
                     f, act_wr.size(), act_rd.size(), ew.size(), er.size());
         end
      end
      total++;
      if (both_hi != 0) begin
         bad++;
         $display("FAIL strobe_overlap got=%0d exp=0", both_hi);
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) exp_mem[i] = 8'(8'hA0 + i);
      @(negedge clk);
      mem_load = 1'b0;
      test_reset();
      test_read_burst();
      test_write_burst();
      test_wrap();
      test_abort();
      test_overrun();
      test_reset_ena();
      test_random_frames();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Frame-level protocol stage directly downstream of the spi_slave byte engine.
- Consumes received bytes (rx strobe + byte), decodes a command/address byte, then runs an auto-incrementing register write or read burst on a simple internal register bus.
- Supplies the next transmit byte to the SPI engine's load input.
- spi_ss high aborts the frame and returns the bridge to idle.

Parameters:
- ADDR_W, 7, register address width; the command byte carries address bits [6:0], zero-extended/truncated to ADDR_W.
- IDLE_BYTE, 8'h00, value driven on tx_data while no read data is pending.

Ports:
- clk  input  1  system clock; all logic is rising-edge
- rst  input  1  synchronous, active-high reset
- ena  input  1  global clock enable; state, counters and registered outputs update only when ena=1
- spi_ss  input  1  slave select from pin, active-low; 1 = deselected (frame abort/end)
- rx_valid  input  1  one-cycle strobe: a full byte has been received
- rx_byte  input  8  received byte, valid when rx_valid=1
- tx_data  output  8  byte the SPI engine loads for its next transmit byte
- reg_addr  output  ADDR_W  register bus address
- reg_wdata  output  8  register bus write data
- reg_we  output  1  one-cycle write strobe
- reg_re  output  1  one-cycle read strobe
- reg_rdata  input  8  read data, valid the cycle after reg_re
- frame_active  output  1  1 from command byte accepted until frame end
- overrun  output  1  sticky: rx byte arrived while read data still pending; cleared at next command byte

Behaviour:
- Reset values: tx_data=IDLE_BYTE, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, frame_active=0, overrun=0, state=IDLE.
- State machine (4 states): IDLE, WRITE, RD_REQ, RD_CAP.
- IDLE + rx_valid: cmd=rx_byte; reg_addr<=cmd[6:0]; frame_active<=1; overrun<=0.
  - cmd[7]=1: go to WRITE.
  - cmd[7]=0: go to RD_REQ.
- WRITE + rx_valid (cycle N): reg_wdata<=rx_byte; reg_we=1 during cycle N+1 with current reg_addr. reg_addr increments after the strobe; it is visible in cycle N+2. Remain in WRITE.
- RD_REQ: reg_re=1 for exactly one cycle at the current reg_addr, then go to RD_CAP.
  - Timing: command rx_valid at cycle N gives reg_re in cycle N+1.
- RD_CAP: sample reg_rdata into tx_data (visible in cycle N+3), increment reg_addr, go to WAIT_RX.
  - WAIT_RX is WRITE-like waiting, implemented as RD_REQ gated by the next rx_valid.
  - Next rx_valid (dummy byte clocked out with the data) triggers the next RD_REQ.
  - Read burst: each received dummy byte fetches the following address; tx_data always holds the byte for the next SPI byte slot.
- rx_valid during RD_REQ or RD_CAP: byte ignored, overrun<=1, sequence continues.
- Address arithmetic: reg_addr wraps modulo 2^ADDR_W (7'h7F+1 -> 7'h00). No error is flagged on wrap.
- spi_ss=1 (synchronous, priority over everything except rst):
  - state<=IDLE, frame_active<=0, tx_data<=IDLE_BYTE.
  - reg_we and reg_re forced 0 in the following cycle; a pending write or read is dropped.
  - reg_addr and overrun hold.
- rx_valid with spi_ss=1 in the same cycle: byte discarded.
- ena=0: all registers hold; strobes are not re-issued; rx_valid with ena=0 is lost (upstream generates strobes only when ena=1).
- reg_we and reg_re are never high in the same cycle; each is at most one cycle wide per byte.
- rst mid-frame: all outputs return to reset values on the next edge; no strobe is issued afterwards.

Test Plan:
- Write burst: ss=0, rx 0x85,0x11,0x22 -> reg_we pulses at addr 0x05 data 0x11, then addr 0x06 data 0x22; frame_active=1; no reg_re.
- Read burst: rx 0x10, reg_rdata returns 0xA0+addr -> reg_re at 0x10 one cycle after strobe; tx_data=0xB0 two cycles later; dummy rx -> reg_re at 0x11, tx_data=0xB1.
- Wrap: write cmd 0xFF, three data bytes -> reg_we addrs 0x7F, 0x00, 0x01.
- Abort: ss goes high one cycle after write data rx_valid -> at most the already-registered reg_we; state IDLE, tx_data=0x00, frame_active=0; new frame cmd accepted normally.
- Overrun: read cmd, then rx_valid in the cycle reg_re is high -> overrun=1, byte ignored; next frame cmd clears overrun to 0.
- Reset/ena: rst mid read burst -> all outputs at reset values; ena=0 for 5 cycles during RD_CAP -> tx_data and state frozen, resume with correct capture when ena=1.
